cnt4bit: RTL and testbench
==========================

Name: cnt4bit

Overview:
- Pin-level model of the 74161 synchronous 4-bit binary counter: asynchronous clear, synchronous parallel load, two count enables, ripple-carry output.
- Part of the struct74 fixed-function IC library.
- Pairs with the 4-bit magnitude comparator in compare/timer datapaths. The counter generates the values; the comparator consumes them (counter Q outputs drive comparator A inputs).
- Cascades through RCO into the ENT of the next stage for wider counters.

Parameters:
- None. Fixed-function part; width is 4 bits, no configuration.

Ports:
- pin2  input  1  CLK, rising-edge clock.
- pin1  input  1  CLR_n, asynchronous active-low clear.
- pin3  input  1  A, load data bit 0.
- pin4  input  1  B, load data bit 1.
- pin5  input  1  C, load data bit 2.
- pin6  input  1  D, load data bit 3.
- pin7  input  1  ENP, count enable P.
- pin8  input  1  GND, unused.
- pin9  input  1  LOAD_n, synchronous active-low parallel load.
- pin10 input  1  ENT, count enable T; also gates RCO.
- pin11 output 1  QD, count bit 3.
- pin12 output 1  QC, count bit 2.
- pin13 output 1  QB, count bit 1.
- pin14 output 1  QA, count bit 0.
- pin15 output 1  RCO, ripple carry out.
- pin16 input  1  VCC, unused.

Behaviour:
- Interface:
  - One clock (pin2, rising edge).
  - Reset is asynchronous and active-low (pin1).
  - Clock and reset carry pin names, like every port of the part.
- State: 4-bit register Q = {QD,QC,QB,QA} = {pin11,pin12,pin13,pin14}.
- Reset:
  - pin1 low forces Q = 4'b0000 immediately, with no clock edge needed.
  - RCO = 0 while pin1 is low.
  - Clear dominates all other controls, including a simultaneous clock edge.
  - While pin1 is held low, clock edges have no effect.
- Reset release:
  - Q holds 0 after pin1 rises.
  - The first state change is on the next rising pin2 edge with pin1 high.
- Rising pin2 edge, pin1 high, in priority order:
  1. pin9 low: load Q = {pin6,pin5,pin4,pin3}. Load ignores ENP and ENT.
  2. pin9 high and pin7 high and pin10 high: Q = (Q + 1) mod 16.
  3. Otherwise: Q holds.
- Wrap-around: 15 counts to 0 with no extra state. Loaded values count up normally from the loaded value.
- RCO:
  - Combinational: RCO = pin10 AND (Q == 4'b1111).
  - Does not depend on ENP, LOAD_n or the clock.
  - Asserts in the same delta as Q reaching 15 or ENT rising.
  - Deasserts when Q leaves 15 or ENT falls.
- Latency:
  - Load and count are visible 1 clock edge after being sampled.
  - Clear has zero latency.
- Outputs are registered, except RCO, which is decoded from the registered Q.
- pin8 and pin16 are declared inputs only. They have no functional effect.
- X or Z on a control pin at an edge: no special handling required. Verification checks 0/1 stimulus only.

Test Plan:
- Reset mid-count:
  - Stimulus: count to Q=9, then pull pin1 low between edges.
  - Required: Q=0 and RCO=0 with no edge; edges while low leave Q=0; after release, the first edge gives Q=1.
- Full wrap:
  - Stimulus: ENP=ENT=1, LOAD_n=1, 17 edges from Q=0.
  - Required: Q steps 0..15,0,1; RCO=1 only while Q=15.
- Load priority:
  - Stimulus: Q=3, ENP=ENT=0, LOAD_n=0, DCBA=1010, one edge.
  - Required: Q=1010; next edge with LOAD_n=1 and enables high gives Q=1011.
- Enable gating:
  - Stimulus: Q=15. Edges with ENP=0, ENT=1, then ENP=1, ENT=0.
  - Required: Q stays 15 throughout; RCO=1 in the first case, RCO=0 in the second (ENT low).
- Cascade with the comparator:
  - Stimulus: two counters; low RCO drives high ENT; high-stage Q feeds the comparator A inputs, with B=0101 and the cascade inputs set to equal. Run 96 edges from 0.
  - Required: comparator A=B out asserts exactly at combined counts 80..95.

Source files
------------

// File: rtl/cnt4bit.sv
// rtl/cnt4bit.sv - 74161 synchronous 4-bit binary counter, pin-level model
module cnt4bit (
    input  logic pin1,   // CLR_n
    input  logic pin2,   // CLK
    input  logic pin3,   // A
    input  logic pin4,   // B
    input  logic pin5,   // C
    input  logic pin6,   // D
    input  logic pin7,   // ENP
    input  logic pin8,   // GND
    input  logic pin9,   // LOAD_n
    input  logic pin10,  // ENT
    output logic pin11,  // QD
    output logic pin12,  // QC
    output logic pin13,  // QB
    output logic pin14,  // QA
    output logic pin15,  // RCO
    input  logic pin16   // VCC
);

    logic [3:0] r_q;
    logic [3:0] w_load_data;
    logic       w_count_en;
    logic       w_unused;

    assign w_load_data = {pin6, pin5, pin4, pin3};
    assign w_count_en  = pin7 & pin10;

    // Supply pins exist only to keep the pinout complete.
    assign w_unused = pin8 ^ pin16;

    // Clear is asynchronous and dominates; load outranks counting.
    always_ff @(posedge pin2 or negedge pin1) begin
        if (!pin1) begin
            r_q <= 4'b0000;
        end else if (!pin9) begin
            r_q <= w_load_data;
        end else if (w_count_en) begin
            r_q <= r_q + 4'd1;
        end
    end

    assign {pin11, pin12, pin13, pin14} = r_q;

    // Terminal count is gated only by ENT so stages can cascade through it.
    assign pin15 = pin10 & (&r_q);

endmodule

// File: tb/tb_cnt4bit.sv
// tb/tb_cnt4bit.sv - randomized self-checking bench for cnt4bit
module tb_cnt4bit;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] din;
    logic       enp;
    logic       ent;
    logic       load_n;
    logic       gnd = 1'b0;
    logic       vcc = 1'b1;

    logic       lo_qd, lo_qc, lo_qb, lo_qa, lo_rco;
    logic       hi_qd, hi_qc, hi_qb, hi_qa, hi_rco;
    logic [3:0] lo_q, hi_q;

    int n_cmp = 0;
    int n_err = 0;
    int m_q   = 0;

    assign lo_q = {lo_qd, lo_qc, lo_qb, lo_qa};
    assign hi_q = {hi_qd, hi_qc, hi_qb, hi_qa};

    always #5 clk = ~clk;

    cnt4bit u_lo (
        .pin1 (clr_n), .pin2 (clk), .pin3 (din[0]), .pin4 (din[1]),
        .pin5 (din[2]), .pin6 (din[3]), .pin7 (enp), .pin8 (gnd),
        .pin9 (load_n), .pin10(ent), .pin11(lo_qd), .pin12(lo_qc),
        .pin13(lo_qb), .pin14(lo_qa), .pin15(lo_rco), .pin16(vcc)
    );

    cnt4bit u_hi (
        .pin1 (clr_n), .pin2 (clk), .pin3 (din[0]), .pin4 (din[1]),
        .pin5 (din[2]), .pin6 (din[3]), .pin7 (enp), .pin8 (gnd),
        .pin9 (load_n), .pin10(lo_rco), .pin11(hi_qd), .pin12(hi_qc),
        .pin13(hi_qb), .pin14(hi_qa), .pin15(hi_rco), .pin16(vcc)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rco();
        return (ent === 1'b1 && m_q == 15) ? 8'd1 : 8'd0;
    endfunction

    // Reference: apply the part's rules at an edge using plain integer arithmetic.
    task automatic edge_check(input string tag);
        if (!clr_n)       m_q = 0;
        else if (!load_n) m_q = int'(din);
        else if (enp && ent) m_q = (m_q + 1) % 16;
        @(posedge clk);
        #1;
        check({tag, "_q"}, {4'd0, lo_q}, m_q[7:0]);
        check({tag, "_rco"}, {7'd0, lo_rco}, exp_rco());
    endtask

    task automatic async_clear();
        clr_n = 1'b0;
        m_q   = 0;
        #1;
        check("clr_q", {4'd0, lo_q}, 8'd0);
        check("clr_rco", {7'd0, lo_rco}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clr_n = 1'b0; din = 4'd0; enp = 1'b0; ent = 1'b0; load_n = 1'b1;
        #2;
        check("rst_q", {4'd0, lo_q}, 8'd0);
        check("rst_rco", {7'd0, lo_rco}, 8'd0);

        // Reset mid-count
        @(posedge clk); #1;
        clr_n = 1'b1; enp = 1'b1; ent = 1'b1;
        for (int i = 0; i < 9; i++) edge_check("cnt9");
        #2;
        async_clear();
        for (int i = 0; i < 3; i++) edge_check("clr_hold");
        clr_n = 1'b1;
        edge_check("rel_first");

        // Full wrap
        #1; async_clear(); clr_n = 1'b1;
        for (int i = 0; i < 17; i++) edge_check("wrap");

        // Load priority
        load_n = 1'b0; din = 4'd3;
        edge_check("ld3");
        enp = 1'b0; ent = 1'b0; din = 4'b1010;
        edge_check("ld_pri");
        load_n = 1'b1; enp = 1'b1; ent = 1'b1;
        edge_check("ld_cnt");

        // Enable gating at terminal count
        load_n = 1'b0; din = 4'd15;
        edge_check("ld15");
        load_n = 1'b1; enp = 1'b0; ent = 1'b1;
        #1; check("gate_rco_ent1", {7'd0, lo_rco}, 8'd1);
        for (int i = 0; i < 2; i++) edge_check("gate_enp0");
        enp = 1'b1; ent = 1'b0;
        #1; check("gate_rco_ent0", {7'd0, lo_rco}, 8'd0);
        for (int i = 0; i < 2; i++) edge_check("gate_ent0");

        // Randomized controls with occasional mid-cycle clears
        for (int i = 0; i < 400; i++) begin
            din    = 4'($urandom_range(0, 15));
            enp    = ($urandom_range(0, 3) != 0);
            ent    = ($urandom_range(0, 3) != 0);
            load_n = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) begin
                #1; async_clear();
                if ($urandom_range(0, 1) == 1) clr_n = 1'b1;
            end else begin
                clr_n = 1'b1;
                #1; check("rnd_rco_comb", {7'd0, lo_rco}, exp_rco());
            end
            edge_check("rnd");
        end

        // Cascade: high stage equals 0101 exactly at combined counts 80..95
        #1; async_clear(); clr_n = 1'b1;
        enp = 1'b1; ent = 1'b1; load_n = 1'b1;
        check("cas_eq0", {7'd0, (hi_q == 4'b0101)}, 8'd0);
        for (n = 1; n <= 96; n++) begin
            @(posedge clk); #1;
            check("cas_cnt", {hi_q, lo_q}, 8'(n % 256));
            check("cas_eq", {7'd0, (hi_q == 4'b0101)}, (n >= 80 && n <= 95) ? 8'd1 : 8'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
